// File: rtl/seg_display_sched_if.sv
// Scheduler bus: default and request sources, converter hookup, panel pins.
// Requests use valid/ack handshakes. Valid stays high until a one-cycle ack.
interface seg_display_sched_if;
  logic [13:0] base_num;
  logic        base_dec;
  logic        req0_valid;
  logic [13:0] req0_num;
  logic        req0_dec;
  logic        req0_ack;
  logic        req1_valid;
  logic [13:0] req1_num;
  logic        req1_dec;
  logic        req1_ack;
  logic [13:0] conv_num;
  logic        conv_dec;
  logic [31:0] conv_seg;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  src;
  logic        busy;

  modport master (
    output base_num, base_dec,
    output req0_valid, req0_num, req0_dec, input req0_ack,
    output req1_valid, req1_num, req1_dec, input req1_ack,
    input  conv_num, conv_dec, output conv_seg,
    input  an, seg, src, busy
  );

  modport slave (
    input  base_num, base_dec,
    input  req0_valid, req0_num, req0_dec, output req0_ack,
    input  req1_valid, req1_num, req1_dec, output req1_ack,
    output conv_num, conv_dec, input conv_seg,
    output an, seg, src, busy
  );
endinterface

// File: rtl/seg_display_sched.sv
// Display scheduler and digit scanner. Accepts in 1 cycle, holds HOLD_CYCLES, pins lag 1 cycle.
// req1 is held off (unacked) during a req0 hold; req0 preempts req1 at any time.
module seg_display_sched #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 200000000
) (
  input logic              clk,
  input logic              reset_n,
  seg_display_sched_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD0 = 2'd1, HOLD1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [13:0]   num_nxt;
  logic          dec_nxt;
  logic          ack0_nxt, ack1_nxt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;

  logic acc0, acc1, expire, scan_wrap;

  // A valid seen while its own ack is high is the same request, not a new one.
  assign expire    = (state != IDLE) && (hold_cnt == '0);
  assign acc0      = bus.req0_valid && !bus.req0_ack;
  assign acc1      = bus.req1_valid && !bus.req1_ack && ((state != HOLD0) || expire);
  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    num_nxt      = bus.conv_num;
    dec_nxt      = bus.conv_dec;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    if (acc0) begin
      state_nxt    = HOLD0;
      hold_cnt_nxt = HW'(HOLD_CYCLES - 1);
      num_nxt      = bus.req0_num;
      dec_nxt      = bus.req0_dec;
      ack0_nxt     = 1'b1;
    end else if (acc1) begin
      state_nxt    = HOLD1;
      hold_cnt_nxt = HW'(HOLD_CYCLES - 1);
      num_nxt      = bus.req1_num;
      dec_nxt      = bus.req1_dec;
      ack1_nxt     = 1'b1;
    end else if (state == IDLE || expire) begin
      state_nxt = IDLE;
      num_nxt   = bus.base_num;
      dec_nxt   = bus.base_dec;
    end else begin
      hold_cnt_nxt = hold_cnt - HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      bus.conv_num <= '0;
      bus.conv_dec <= 1'b0;
      bus.req0_ack <= 1'b0;
      bus.req1_ack <= 1'b0;
      bus.src      <= 2'd0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      bus.conv_num <= num_nxt;
      bus.conv_dec <= dec_nxt;
      bus.req0_ack <= ack0_nxt;
      bus.req1_ack <= ack1_nxt;
      bus.src      <= 2'(state_nxt);
      bus.busy     <= (state_nxt != IDLE);
    end
  end

  // Scanning runs regardless of scheduler state; leftmost digit is lit first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx      <= 2'd3;
      bus.an   <= 4'b1111;
      bus.seg  <= 8'hFF;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap) idx <= idx - 2'd1;
      bus.an  <= ~(4'b0001 << idx);
      bus.seg <= bus.conv_seg[{idx, 3'b000} +: 8];
    end
  end
endmodule
